// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU constants and the write-back entry type used by the
//               execute, memory and write-back stages.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_WIDTH    = 16;
    localparam int REGADDR_WIDTH = 3;

    typedef struct packed {
        logic [REGADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous FIFO of write-back entries with per-slot
//               valid/rd export for hazard tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int ALU_DEPTH = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    push,
    input  logic                                    pop,
    input  wb_entry_t                               push_entry,
    output wb_entry_t                               head,
    output logic                                    full,
    output logic                                    empty,
    output logic [ALU_DEPTH-1:0]                    slot_valid,
    output logic [ALU_DEPTH-1:0][REGADDR_WIDTH-1:0] slot_rd
);

    localparam int IDX_W = $clog2(ALU_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    wb_entry_t        r_mem [ALU_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_count;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign empty   = (r_wr_ptr == r_rd_ptr);
    // Same slot index with differing wrap bits means the pointers are a lap apart.
    assign full    = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                     (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
    assign head    = r_mem[r_rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !reset) begin
            r_mem[r_wr_ptr[IDX_W-1:0]] <= push_entry;
        end
    end

    generate
        for (genvar i = 0; i < ALU_DEPTH; i++) begin : g_slot
            logic [IDX_W-1:0] w_off;
            // A slot is live when its distance from the read pointer is below the fill count.
            assign w_off         = IDX_W'(i) - r_rd_ptr[IDX_W-1:0];
            assign slot_valid[i] = ({1'b0, w_off} < w_count);
            assign slot_rd[i]    = r_mem[i].rd;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Merges ALU and memory-unit results onto the single register
//               file write port and exports a pending-write bitmap.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int ALU_DEPTH = 2,
    parameter int NUM_REGS  = 1 << REGADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [REGADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [REGADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    output logic                     reg_write,
    output logic [REGADDR_WIDTH-1:0] write_reg,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic [NUM_REGS-1:0]      pending
);

    wb_entry_t                               w_head;
    wb_entry_t                               w_alu_entry;
    wb_entry_t                               w_win;
    logic                                    w_full;
    logic                                    w_empty;
    logic                                    w_push;
    logic                                    w_pop;
    logic                                    w_win_valid;
    logic [ALU_DEPTH-1:0]                    w_slot_valid;
    logic [ALU_DEPTH-1:0][REGADDR_WIDTH-1:0] w_slot_rd;

    logic                     r_reg_write;
    logic [REGADDR_WIDTH-1:0] r_write_reg;
    logic [DATA_WIDTH-1:0]    r_write_data;

    assign alu_ready   = !w_full && !reset;
    assign mem_ready   = !w_full && !reset;
    assign w_push      = alu_valid && alu_ready;
    assign w_alu_entry = '{rd: alu_rd, data: alu_data};

    // The head is forced out when full so a busy memory unit cannot starve the ALU.
    assign w_pop = !reset && !w_empty && (w_full || !mem_valid);

    always_comb begin
        w_win_valid = 1'b0;
        w_win       = w_head;
        if (w_pop) begin
            w_win_valid = 1'b1;
        end else if (mem_valid && mem_ready) begin
            w_win_valid = 1'b1;
            w_win       = '{rd: mem_rd, data: mem_data};
        end
    end

    wb_fifo #(
        .ALU_DEPTH (ALU_DEPTH)
    ) u_wb_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .pop        (w_pop),
        .push_entry (w_alu_entry),
        .head       (w_head),
        .full       (w_full),
        .empty      (w_empty),
        .slot_valid (w_slot_valid),
        .slot_rd    (w_slot_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else if (w_win_valid && (w_win.rd != '0)) begin
            r_reg_write  <= 1'b1;
            r_write_reg  <= w_win.rd;
            r_write_data <= w_win.data;
        end else begin
            r_reg_write  <= 1'b0;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < ALU_DEPTH; i++) begin
            if (w_slot_valid[i]) begin
                pending[w_slot_rd[i]] = 1'b1;
            end
        end
        if (r_reg_write) begin
            pending[r_write_reg] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    assign reg_write  = r_reg_write;
    assign write_reg  = r_write_reg;
    assign write_data = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter: directed scenarios plus
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int c_DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [2:0]  alu_rd = '0;
    logic [15:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [2:0]  mem_rd = '0;
    logic [15:0] mem_data = '0;
    logic        reg_write;
    logic [2:0]  write_reg;
    logic [15:0] write_data;
    logic [7:0]  pending;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int          q_rd[$];
    int          q_data[$];
    logic        exp_rw = 1'b0;
    logic [2:0]  exp_wr = '0;
    logic [15:0] exp_wd = '0;

    always #5 clk = ~clk;

    wb_arbiter #(.ALU_DEPTH(c_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .pending    (pending)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] model_pending();
        logic [7:0] p = '0;
        foreach (q_rd[i]) p[q_rd[i]] = 1'b1;
        if (exp_rw) p[exp_wr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic compare();
        logic exp_rdy;
        exp_rdy = (q_rd.size() < c_DEPTH) && !reset;
        chk("alu_ready", alu_ready, exp_rdy);
        chk("mem_ready", mem_ready, exp_rdy);
        chk("reg_write", reg_write, exp_rw);
        chk("pending", pending, model_pending());
        if (exp_rw) begin
            chk("write_reg", write_reg, exp_wr);
            chk("write_data", write_data, exp_wd);
        end
    endtask

    task automatic drive(input logic rst, input logic av, input logic [2:0] ard, input logic [15:0] ad,
                         input logic mv, input logic [2:0] mrd, input logic [15:0] md);
        @(negedge clk);
        reset = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        #1;
        compare();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    endtask

    // Advance one edge and apply the arbitration rules to the model.
    task automatic tick();
        bit full, win;
        int wrd, wdat;
        @(posedge clk);
        if (reset) begin
            q_rd.delete(); q_data.delete();
            exp_rw = 1'b0; exp_wr = '0; exp_wd = '0;
        end else begin
            full = (q_rd.size() == c_DEPTH);
            win  = 1'b0;
            if (full || (!mem_valid && q_rd.size() > 0)) begin
                win = 1'b1; wrd = q_rd.pop_front(); wdat = q_data.pop_front();
            end else if (mem_valid) begin
                win = 1'b1; wrd = mem_rd; wdat = mem_data;
            end
            if (alu_valid && !full) begin
                q_rd.push_back(alu_rd); q_data.push_back(alu_data);
            end
            if (win && wrd != 0) begin
                exp_rw = 1'b1; exp_wr = 3'(wrd); exp_wd = 16'(wdat);
            end else begin
                exp_rw = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);

        // Reset
        drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        chk("rst_alu_ready", alu_ready, 1'b0);
        chk("rst_mem_ready", mem_ready, 1'b0);
        tick();
        chk("rst_reg_write", reg_write, 1'b0);
        chk("rst_write_reg", write_reg, 3'd0);
        chk("rst_write_data", write_data, 16'h0);
        chk("rst_pending", pending, 8'h00);
        idle();
        chk("post_rst_alu_ready", alu_ready, 1'b1);
        chk("post_rst_mem_ready", mem_ready, 1'b1);
        tick();

        // Single memory write
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h1234);
        chk("mem_ready_n", mem_ready, 1'b1);
        tick();
        chk("mem_rw_n1", reg_write, 1'b1);
        chk("mem_wr_n1", write_reg, 3'd3);
        chk("mem_wd_n1", write_data, 16'h1234);
        chk("mem_pend_n1", pending, 8'h08);
        idle(); tick();
        chk("mem_pend_n2", pending, 8'h00);

        // Single ALU write
        drive(1'b0, 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 16'h0);
        tick();
        chk("alu_pend_n1", pending, 8'h20);
        chk("alu_rw_n1", reg_write, 1'b0);
        idle(); tick();
        chk("alu_rw_n2", reg_write, 1'b1);
        chk("alu_wr_n2", write_reg, 3'd5);
        chk("alu_wd_n2", write_data, 16'hBEEF);
        chk("alu_pend_n2", pending, 8'h20);
        idle(); tick();
        chk("alu_pend_n3", pending, 8'h00);

        // Simultaneous ALU and memory
        drive(1'b0, 1'b1, 3'd1, 16'h0001, 1'b1, 3'd2, 16'h0002);
        tick();
        chk("sim_wr_first", write_reg, 3'd2);
        chk("sim_wd_first", write_data, 16'h0002);
        idle(); tick();
        chk("sim_wr_second", write_reg, 3'd1);
        chk("sim_wd_second", write_data, 16'h0001);
        idle(); tick();

        // Full FIFO with continuous memory traffic
        drive(1'b0, 1'b1, 3'd1, 16'h0011, 1'b1, 3'd4, 16'h0044); tick();
        drive(1'b0, 1'b1, 3'd2, 16'h0022, 1'b1, 3'd4, 16'h0045); tick();
        drive(1'b0, 1'b0, 3'd0, 16'h0,    1'b1, 3'd4, 16'h0046);
        chk("full_alu_ready", alu_ready, 1'b0);
        chk("full_mem_ready", mem_ready, 1'b0);
        tick();
        chk("full_head_wr", write_reg, 3'd1);
        chk("full_head_wd", write_data, 16'h0011);
        drive(1'b0, 1'b1, 3'd3, 16'h0033, 1'b1, 3'd4, 16'h0046); tick();
        chk("refill_mem_wd", write_data, 16'h0046);
        drive(1'b0, 1'b0, 3'd0, 16'h0,    1'b1, 3'd4, 16'h0047); tick();
        chk("refill_head_wd", write_data, 16'h0022);
        repeat (4) begin idle(); tick(); end

        // Register 0
        drive(1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 16'h0);
        chk("r0_alu_ready", alu_ready, 1'b1);
        tick();
        chk("r0_pend0_n1", pending[0], 1'b0);
        idle(); tick();
        chk("r0_rw_n2", reg_write, 1'b0);
        idle(); tick();
        chk("r0_rw_n3", reg_write, 1'b0);

        // Reset mid-flight with two buffered ALU entries
        drive(1'b0, 1'b1, 3'd6, 16'h0066, 1'b1, 3'd3, 16'h0300); tick();
        drive(1'b0, 1'b1, 3'd7, 16'h0077, 1'b1, 3'd3, 16'h0301); tick();
        chk("mid_pend_full", pending, 8'hC8);
        drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        chk("mid_rst_alu_ready", alu_ready, 1'b0);
        chk("mid_rst_mem_ready", mem_ready, 1'b0);
        tick();
        chk("mid_rst_rw", reg_write, 1'b0);
        chk("mid_rst_pend", pending, 8'h00);
        idle();
        chk("mid_post_alu_ready", alu_ready, 1'b1);
        tick();
        chk("mid_post_rw", reg_write, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 99) < 60), 3'($urandom), 16'($urandom),
                  ($urandom_range(0, 99) < 50), 3'($urandom), 16'($urandom));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
